// File: rtl/zxuno_regs_pkg.sv
// Shared constants, FSM encoding and I/O port decode for the ZX-UNO register controller.
package zxuno_regs_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PORT_W = 16;

  localparam logic [PORT_W-1:0] ZXUNO_ADDR_PORT = 16'hFC3B;
  localparam logic [PORT_W-1:0] ZXUNO_DATA_PORT = 16'hFD3B;

  // Register numbers of the ZX-UNO extended register space
  localparam logic [DATA_W-1:0] REG_MASTERCONF   = 8'h00;
  localparam logic [DATA_W-1:0] REG_MASTERMAPPER = 8'h01;
  localparam logic [DATA_W-1:0] REG_FLASHSPI     = 8'h02;
  localparam logic [DATA_W-1:0] REG_FLASHCS      = 8'h03;
  localparam logic [DATA_W-1:0] REG_SCANCODE     = 8'h04;
  localparam logic [DATA_W-1:0] REG_KEYBSTAT     = 8'h05;
  localparam logic [DATA_W-1:0] REG_JOYCONF      = 8'h06;
  localparam logic [DATA_W-1:0] REG_COREID       = 8'hFF;

  // Value returned on the bus when nobody drives read data
  localparam logic [DATA_W-1:0] RD_IDLE = 8'hFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } access_state_e;

  typedef struct packed {
    logic aw;
    logic ar;
    logic dw;
    logic dr;
  } io_decode_t;

  // Simultaneous rd/wr strobes are treated as no access at all.
  function automatic io_decode_t io_decode(input logic [PORT_W-1:0] addr_v,
                                           input logic              iorq_n_v,
                                           input logic              rd_n_v,
                                           input logic              wr_n_v);
    io_decode_t d;
    logic rd_cyc;
    logic wr_cyc;
    rd_cyc = !iorq_n_v && !rd_n_v && wr_n_v;
    wr_cyc = !iorq_n_v && !wr_n_v && rd_n_v;
    d.aw   = wr_cyc && (addr_v == ZXUNO_ADDR_PORT);
    d.ar   = rd_cyc && (addr_v == ZXUNO_ADDR_PORT);
    d.dw   = wr_cyc && (addr_v == ZXUNO_DATA_PORT);
    d.dr   = rd_cyc && (addr_v == ZXUNO_DATA_PORT);
    return d;
  endfunction

endpackage

// File: rtl/io_access_fsm.sv
// IDLE/ACTIVE tracker for one write condition: holds the last written byte and
// commits it with a one-cycle pulse on the first sample after the strobe ends.
module io_access_fsm
  import zxuno_regs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cond_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] data_o,
  output logic              pulse_o
);

  access_state_e     state_q, state_d;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] hold_q,  hold_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              pulse_q, pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      hold_q  <= '0;
      data_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
    end
  end

  // An access already running when reset releases must first be seen idle (armed).
  always_comb begin
    state_d = state_q;
    armed_d = armed_q | !cond_i;
    hold_d  = hold_q;
    data_d  = data_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cond_i && armed_q) begin
          state_d = ST_ACTIVE;
          hold_d  = din_i;
        end
      end
      ST_ACTIVE: begin
        if (cond_i) begin
          hold_d = din_i;
        end else begin
          state_d = ST_IDLE;
          data_d  = hold_q;
          pulse_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_o  = data_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/zxuno_regs_ctrl.sv
// ZX-UNO register-space controller: FC3B/FD3B decode, register select/write
// strobes and prioritised read-back of peripheral data onto the CPU bus.
module zxuno_regs_ctrl
  import zxuno_regs_pkg::*;
#(
  parameter int unsigned N_PERIPH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORT_W-1:0]          a,
  input  logic                       iorq_n,
  input  logic                       rd_n,
  input  logic                       wr_n,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       oe_n,
  output logic [DATA_W-1:0]          zxuno_addr,
  output logic                       zxuno_regrd,
  output logic                       zxuno_regwr,
  output logic [DATA_W-1:0]          zxuno_wrdata,
  output logic                       regaddr_changed,
  input  logic [DATA_W*N_PERIPH-1:0] per_dout,
  input  logic [N_PERIPH-1:0]        per_oe_n,
  output logic                       conflict
);

  io_decode_t        dec_c;
  logic [DATA_W-1:0] per_sel_c;
  logic              per_hit_c;
  logic              per_multi_c;

  logic [DATA_W-1:0] dout_q,     dout_d;
  logic              oe_n_q,     oe_n_d;
  logic              regrd_q,    regrd_d;
  logic              conflict_q, conflict_d;

  assign dec_c = io_decode(a, iorq_n, rd_n, wr_n);

  io_access_fsm u_addr_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .cond_i  (dec_c.aw),
    .din_i   (din),
    .data_o  (zxuno_addr),
    .pulse_o (regaddr_changed)
  );

  io_access_fsm u_data_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .cond_i  (dec_c.dw),
    .din_i   (din),
    .data_o  (zxuno_wrdata),
    .pulse_o (zxuno_regwr)
  );

  // Lowest-index claimant wins; a second claimant flags a multi-drive.
  always_comb begin
    per_sel_c   = RD_IDLE;
    per_hit_c   = 1'b0;
    per_multi_c = 1'b0;
    for (int i = 0; i < int'(N_PERIPH); i++) begin
      if (!per_oe_n[i]) begin
        if (!per_hit_c) per_sel_c = per_dout[DATA_W*i +: DATA_W];
        per_multi_c = per_multi_c | per_hit_c;
        per_hit_c   = 1'b1;
      end
    end
  end

  always_comb begin
    oe_n_d     = !(dec_c.ar | dec_c.dr);
    regrd_d    = dec_c.dr;
    conflict_d = conflict_q | (regrd_q & per_multi_c);
    dout_d     = RD_IDLE;
    if (dec_c.ar) begin
      dout_d = zxuno_addr;
    end else if (dec_c.dr) begin
      dout_d = per_sel_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= RD_IDLE;
      oe_n_q     <= 1'b1;
      regrd_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      oe_n_q     <= oe_n_d;
      regrd_q    <= regrd_d;
      conflict_q <= conflict_d;
    end
  end

  assign dout        = dout_q;
  assign oe_n        = oe_n_q;
  assign zxuno_regrd = regrd_q;
  assign conflict    = conflict_q;

endmodule

// File: tb/tb_zxuno_regs_ctrl.sv
// Bench for zxuno_regs_ctrl: directed vector table, multi-cycle corner sequences
// and randomized bus traffic checked against a transaction-level model.
module tb_zxuno_regs_ctrl;

  localparam int unsigned NP = 8;
  localparam logic [63:0] PD = 64'h0000_7700_0033_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   a;
  logic          iorq_n, rd_n, wr_n;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic          oe_n;
  logic [7:0]    zxuno_addr;
  logic          zxuno_regrd, zxuno_regwr;
  logic [7:0]    zxuno_wrdata;
  logic          regaddr_changed;
  logic [8*NP-1:0] per_dout;
  logic [NP-1:0] per_oe_n;
  logic          conflict;

  int n_cmp = 0;
  int n_bad = 0;

  zxuno_regs_ctrl #(.N_PERIPH(NP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .a               (a),
    .iorq_n          (iorq_n),
    .rd_n            (rd_n),
    .wr_n            (wr_n),
    .din             (din),
    .dout            (dout),
    .oe_n            (oe_n),
    .zxuno_addr      (zxuno_addr),
    .zxuno_regrd     (zxuno_regrd),
    .zxuno_regwr     (zxuno_regwr),
    .zxuno_wrdata    (zxuno_wrdata),
    .regaddr_changed (regaddr_changed),
    .per_dout        (per_dout),
    .per_oe_n        (per_oe_n),
    .conflict        (conflict)
  );

  always #5 clk = ~clk;

  // Transaction-level expectations
  logic [7:0] m_addr, m_wrdata, m_dout;
  logic       m_oe_n, m_regrd, m_regwr, m_rac, m_conf;
  bit         m_aw_armed, m_dw_armed, m_aw_run, m_dw_run;
  logic [7:0] m_aw_byte, m_dw_byte;

  typedef struct {
    logic       iorq_n, rd_n, wr_n;
    logic [15:0] a;
    logic [7:0] din;
    logic [7:0] poe_n;
    logic [7:0] e_addr, e_wrdata, e_dout;
    logic       e_oe_n, e_regrd, e_regwr, e_rac, e_conf;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic iq, logic rd, logic wr, logic [15:0] aa, logic [7:0] d,
                              logic [7:0] poe, logic [7:0] ea, logic [7:0] ew, logic [7:0] ed,
                              logic eoe, logic erd, logic ewr, logic erac, logic econf);
    vec_t v;
    v.iorq_n = iq; v.rd_n = rd; v.wr_n = wr; v.a = aa; v.din = d; v.poe_n = poe;
    v.e_addr = ea; v.e_wrdata = ew; v.e_dout = ed; v.e_oe_n = eoe;
    v.e_regrd = erd; v.e_regwr = ewr; v.e_rac = erac; v.e_conf = econf;
    return v;
  endfunction

  task automatic chk8(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_vals(string tag, logic [7:0] ea, logic [7:0] ew, logic [7:0] ed,
                            logic eoe, logic erd, logic ewr, logic erac, logic econf);
    chk8({tag, ".addr"},   zxuno_addr,      ea);
    chk8({tag, ".wrdata"}, zxuno_wrdata,    ew);
    chk8({tag, ".dout"},   dout,            ed);
    chk1({tag, ".oe_n"},   oe_n,            eoe);
    chk1({tag, ".regrd"},  zxuno_regrd,     erd);
    chk1({tag, ".regwr"},  zxuno_regwr,     ewr);
    chk1({tag, ".addrchg"}, regaddr_changed, erac);
    chk1({tag, ".conflict"}, conflict,      econf);
  endtask

  task automatic check_model(string tag);
    check_vals(tag, m_addr, m_wrdata, m_dout, m_oe_n, m_regrd, m_regwr, m_rac, m_conf);
  endtask

  task automatic model_reset();
    m_addr = 8'h00; m_wrdata = 8'h00; m_dout = 8'hFF;
    m_oe_n = 1'b1; m_regrd = 1'b0; m_regwr = 1'b0; m_rac = 1'b0; m_conf = 1'b0;
    m_aw_armed = 0; m_dw_armed = 0; m_aw_run = 0; m_dw_run = 0;
    m_aw_byte = 8'h00; m_dw_byte = 8'h00;
  endtask

  // Evaluate what the coming rising edge does given the inputs now on the bus.
  task automatic model_step();
    bit aw, ar, dw, dr;
    int claims;
    logic [7:0] pick;
    if (!rst_n) begin
      model_reset();
      return;
    end
    aw = !iorq_n && !wr_n && rd_n && a == 16'hFC3B;
    ar = !iorq_n && !rd_n && wr_n && a == 16'hFC3B;
    dw = !iorq_n && !wr_n && rd_n && a == 16'hFD3B;
    dr = !iorq_n && !rd_n && wr_n && a == 16'hFD3B;
    claims = $countones(~per_oe_n);
    pick = 8'hFF;
    for (int i = NP - 1; i >= 0; i--) if (!per_oe_n[i]) pick = per_dout[8*i +: 8];
    if (m_regrd && claims >= 2) m_conf = 1'b1;
    m_dout  = ar ? m_addr : (dr ? pick : 8'hFF);
    m_oe_n  = !(ar || dr);
    m_regrd = dr;
    m_rac = 1'b0;
    if (aw) begin
      if (m_aw_armed) m_aw_run = 1;
      m_aw_byte = din;
    end else begin
      if (m_aw_run) begin m_addr = m_aw_byte; m_rac = 1'b1; end
      m_aw_run = 0; m_aw_armed = 1;
    end
    m_regwr = 1'b0;
    if (dw) begin
      if (m_dw_armed) m_dw_run = 1;
      m_dw_byte = din;
    end else begin
      if (m_dw_run) begin m_wrdata = m_dw_byte; m_regwr = 1'b1; end
      m_dw_run = 0; m_dw_armed = 1;
    end
  endtask

  task automatic set_bus(logic iq, logic rd, logic wr, logic [15:0] aa, logic [7:0] d);
    iorq_n = iq; rd_n = rd; wr_n = wr; a = aa; din = d;
  endtask

  task automatic step(string tag);
    model_step();
    @(posedge clk); #1;
    check_model(tag);
  endtask

  initial begin
    int periods;
    bit prev, seen_wr;
    vec_t v;

    set_bus(1, 1, 1, 16'h0000, 8'h00);
    per_oe_n = 8'hFF;
    per_dout = PD;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_vals("reset", 8'h00, 8'h00, 8'hFF, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // iq rd wr a din poe | addr wrdata dout oe rrd rwr rac conf
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'h00,8'h00,8'hFF,1,0,0,0,0));
    tv.push_back(mk(0,1,0,16'hFC3B,8'hFF,8'hFF, 8'h00,8'h00,8'hFF,1,0,0,0,0));
    tv.push_back(mk(0,1,0,16'hFC3B,8'hFF,8'hFF, 8'h00,8'h00,8'hFF,1,0,0,0,0));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'hFF,8'h00,8'hFF,1,0,0,1,0));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'hFF,8'h00,8'hFF,1,0,0,0,0));
    tv.push_back(mk(0,1,0,16'hFC3B,8'h0B,8'hFF, 8'hFF,8'h00,8'hFF,1,0,0,0,0));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'h0B,8'h00,8'hFF,1,0,0,1,0));
    tv.push_back(mk(0,1,0,16'hFD3B,8'h5A,8'hFF, 8'h0B,8'h00,8'hFF,1,0,0,0,0));
    tv.push_back(mk(0,1,0,16'hFD3B,8'h5A,8'hFF, 8'h0B,8'h00,8'hFF,1,0,0,0,0));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'h0B,8'h5A,8'hFF,1,0,1,0,0));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'h0B,8'h5A,8'hFF,1,0,0,0,0));
    tv.push_back(mk(0,0,1,16'hFD3B,8'h00,8'hDB, 8'h0B,8'h5A,8'h33,0,1,0,0,0));
    tv.push_back(mk(0,0,1,16'hFD3B,8'h00,8'hDB, 8'h0B,8'h5A,8'h33,0,1,0,0,1));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'h0B,8'h5A,8'hFF,1,0,0,0,1));
    tv.push_back(mk(0,0,1,16'hFD3B,8'h00,8'hFF, 8'h0B,8'h5A,8'hFF,0,1,0,0,1));
    tv.push_back(mk(0,0,1,16'hFC3B,8'h00,8'hFF, 8'h0B,8'h5A,8'h0B,0,0,0,0,1));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'h0B,8'h5A,8'hFF,1,0,0,0,1));
    tv.push_back(mk(0,0,0,16'hFD3B,8'h77,8'hFF, 8'h0B,8'h5A,8'hFF,1,0,0,0,1));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'h0B,8'h5A,8'hFF,1,0,0,0,1));
    tv.push_back(mk(0,1,0,16'hFD3B,8'h11,8'hFF, 8'h0B,8'h5A,8'hFF,1,0,0,0,1));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'h0B,8'h11,8'hFF,1,0,1,0,1));
    tv.push_back(mk(0,1,0,16'hFD3B,8'h22,8'hFF, 8'h0B,8'h11,8'hFF,1,0,0,0,1));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'h0B,8'h22,8'hFF,1,0,1,0,1));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'h0B,8'h22,8'hFF,1,0,0,0,1));
    tv.push_back(mk(0,1,0,16'hFD3B,8'h44,8'hFF, 8'h0B,8'h22,8'hFF,1,0,0,0,1));
    tv.push_back(mk(0,1,0,16'hFD3C,8'h99,8'hFF, 8'h0B,8'h44,8'hFF,1,0,1,0,1));
    tv.push_back(mk(1,1,1,16'h0000,8'h00,8'hFF, 8'h0B,8'h44,8'hFF,1,0,0,0,1));

    foreach (tv[k]) begin
      v = tv[k];
      set_bus(v.iorq_n, v.rd_n, v.wr_n, v.a, v.din);
      per_oe_n = v.poe_n;
      per_dout = PD;
      model_step();
      @(posedge clk); #1;
      check_vals($sformatf("vec%0d", k), v.e_addr, v.e_wrdata, v.e_dout, v.e_oe_n,
                 v.e_regrd, v.e_regwr, v.e_rac, v.e_conf);
    end

    // Three 4-cycle data reads separated by one idle sample each
    periods = 0;
    prev = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        set_bus(0, 0, 1, 16'hFD3B, 8'h00);
        step("rd3");
        if (zxuno_regrd && !prev) periods++;
        prev = zxuno_regrd;
      end
      set_bus(1, 1, 1, 16'h0000, 8'h00);
      step("rd3_idle");
      chk1("rd3_fall", zxuno_regrd, 1'b0);
      prev = zxuno_regrd;
    end
    chk_int("rd3_periods", periods, 3);

    // Reset pulsed in the middle of a data write, with the write held across release
    seen_wr = 0;
    set_bus(0, 1, 0, 16'hFD3B, 8'hA5);
    step("rstw");
    step("rstw");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_vals("rst_mid", 8'h00, 8'h00, 8'hFF, 1, 0, 0, 0, 0);
    step("rst_low");
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step("rst_hold");
      seen_wr |= zxuno_regwr;
    end
    set_bus(1, 1, 1, 16'h0000, 8'h00);
    for (int c = 0; c < 2; c++) begin
      step("rst_after");
      seen_wr |= zxuno_regwr;
    end
    chk1("rst_nopulse", seen_wr, 1'b0);
    set_bus(0, 1, 0, 16'hFD3B, 8'h3C);
    step("post_rst_dw");
    set_bus(1, 1, 1, 16'h0000, 8'h00);
    step("post_rst_commit");
    chk1("post_rst_regwr", zxuno_regwr, 1'b1);
    chk8("post_rst_wrdata", zxuno_wrdata, 8'h3C);

    // Randomized bus traffic against the model
    for (int s = 0; s < 900; s++) begin
      int kind, len;
      logic [15:0] aa;
      kind = $urandom_range(0, 5);
      len  = $urandom_range(1, 4);
      case ($urandom_range(0, 3))
        0:       aa = 16'hFC3B;
        1:       aa = 16'hFD3B;
        2:       aa = 16'hFC3C;
        default: aa = 16'($urandom);
      endcase
      for (int c = 0; c < len; c++) begin
        case (kind)
          0: set_bus(1, 1, 1, 16'h0000, 8'($urandom));
          1: set_bus(0, 1, 0, 16'hFC3B, 8'($urandom));
          2: set_bus(0, 0, 1, 16'hFC3B, 8'($urandom));
          3: set_bus(0, 1, 0, 16'hFD3B, 8'($urandom));
          4: set_bus(0, 0, 1, 16'hFD3B, 8'($urandom));
          default: set_bus(1'($urandom), 1'($urandom), 1'($urandom), aa, 8'($urandom));
        endcase
        case ($urandom_range(0, 3))
          0:       per_oe_n = 8'hFF;
          1, 3:    per_oe_n = ~(8'h01 << $urandom_range(0, 7));
          default: per_oe_n = 8'($urandom);
        endcase
        per_dout = {$urandom, $urandom};
        step("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
